// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between the writeback stage and buffered MDU results
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   wb_rf_en/wb_rd/wb_data     writeback stage write request (rd 0 means no request)
//   mdu_valid/mdu_ready        MDU result handshake, mdu_rd/mdu_data carry the result
//   stall                      hold the pipeline for one cycle while a starved MDU entry drains
//   mdu_pend                   per-register flags for results still waiting in the buffer
//   rf_we/rf_waddr/rf_wdata    registered register-file write port
module rf_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_rf_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        stall,
    output logic [31:0] mdu_pend,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [3:0]       starve_cnt;
    logic             push, pop, wb_req, wb_grant;
    logic [31:0]      pend_raw;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign mdu_ready = !rst && (count < CW'(DEPTH));
    assign stall     = !rst && (starve_cnt == 4'(STARVE_MAX));
    assign push      = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    assign wb_req    = wb_rf_en && (wb_rd != 5'd0);
    // A stall always finds the buffer non-empty: the counter only advances while entries wait.
    assign pop       = (count != '0) && (stall || !wb_req);
    assign wb_grant  = !stall && wb_req;

    always_comb begin
        pend_raw = '0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i]) pend_raw[rd_q[i]] = 1'b1;
        mdu_pend = rst ? '0 : pend_raw;
    end

    always_ff @(posedge clk)
        if (push) begin
            rd_q[wr_ptr]   <= mdu_rd;
            data_q[wr_ptr] <= mdu_data;
        end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            vld        <= '0;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            // Clear before set so a push landing on the slot just popped keeps its valid bit.
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= inc(rd_ptr);
            end
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= inc(wr_ptr);
            end
            count      <= count + CW'(push) - CW'(pop);
            starve_cnt <= (count == '0 || pop) ? 4'd0 :
                          (starve_cnt == 4'(STARVE_MAX)) ? starve_cnt : starve_cnt + 4'd1;
            rf_we      <= pop || wb_grant;
            if (pop) begin
                rf_waddr <= rd_q[rd_ptr];
                rf_wdata <= data_q[rd_ptr];
            end else if (wb_grant) begin
                rf_waddr <= wb_rd;
                rf_wdata <= wb_data;
            end
        end
    end
endmodule
